// File: rtl/drive_pkg.sv
// Shared state encodings and wheel-direction constants for the drive recovery sequencer.
package drive_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StStop    = 3'd2,
        StReverse = 3'd3,
        StTurn    = 3'd4,
        StFault   = 3'd5
    } state_e;

    // {left,right} wheel direction, 1 = forward
    localparam logic [1:0] DirFwd   = 2'b11;
    localparam logic [1:0] DirRev   = 2'b00;
    localparam logic [1:0] DirSpinR = 2'b10;
    localparam logic [1:0] DirSpinL = 2'b01;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Up-counter for the timed recovery phases; done on terminal count, cleared by load.
module phase_timer #(
    parameter int unsigned Width = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] len,
    output logic             done
);

    logic [Width-1:0] cnt_q;

    assign done = (cnt_q == len - Width'(1));

    // Holds at terminal count instead of wrapping while the owner is not in a timed phase.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt_q <= '0;
        end else if (!done) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

endmodule

// File: rtl/drive_recovery_sequencer.sv
// Phased stop / back-off / turn-away recovery between navigation and the motor drivers,
// with a retry window that latches a fault after repeated hits.
module drive_recovery_sequencer
    import drive_pkg::*;
#(
    parameter int unsigned STOP_CYC  = 75_000,
    parameter int unsigned REV_CYC   = 32_500,
    parameter int unsigned TURN_CYC  = 50_000,
    parameter int unsigned WIN_CYC   = 200_000,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned DUTY_W    = 8,
    parameter int unsigned REV_DUTY  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        SnsDisable,
    input  logic              nav_en,
    input  logic [1:0]        nav_dir,
    input  logic [DUTY_W-1:0] nav_duty,
    input  logic              fault_clr,
    output logic              motor_en,
    output logic [1:0]        dir,
    output logic [DUTY_W-1:0] duty,
    output logic [StateW-1:0] state,
    output logic [1:0]        retry_cnt,
    output logic              fault
);

    localparam int unsigned TimerW = $clog2(max3(STOP_CYC, REV_CYC, TURN_CYC) + 1);
    localparam int unsigned WinW   = $clog2(WIN_CYC + 1);

    state_e            state_q, state_d;
    logic [1:0]        side_q, side_d;
    logic [1:0]        retry_q, retry_d;
    logic [WinW-1:0]   win_q, win_d;
    logic              motor_en_q, motor_en_d;
    logic [1:0]        dir_q, dir_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              fault_q, fault_d;

    logic              hit;
    logic              timer_load;
    logic              timer_done;
    logic [TimerW-1:0] timer_len;

    phase_timer #(
        .Width(TimerW)
    ) u_phase_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .len (timer_len),
        .done(timer_done)
    );

    assign timer_load = (state_d != state_q);

    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        retry_d   = retry_q;
        win_d     = win_q;
        hit       = 1'b0;
        timer_len = TimerW'(STOP_CYC);

        case (state_q)
            StIdle: begin
                if (nav_en) state_d = StRun;
            end
            StRun: begin
                if (|SnsDisable) hit = 1'b1;
                else if (!nav_en) state_d = StIdle;
            end
            StStop: begin
                side_d = side_q | SnsDisable;
                if (timer_done) state_d = StReverse;
            end
            StReverse: begin
                timer_len = TimerW'(REV_CYC);
                if (timer_done) state_d = StTurn;
            end
            StTurn: begin
                timer_len = TimerW'(TURN_CYC);
                if (|SnsDisable) hit = 1'b1;
                else if (timer_done) state_d = nav_en ? StRun : StIdle;
            end
            StFault: begin
                if (fault_clr) begin
                    state_d = StIdle;
                    retry_d = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A hit overrides any other exit; the window restarts from zero.
        if (hit) begin
            side_d = SnsDisable;
            win_d  = '0;
            if (({1'b0, retry_q} + 3'd1) == 3'(MAX_RETRY)) begin
                state_d = StFault;
            end else begin
                retry_d = retry_q + 2'd1;
                state_d = StStop;
            end
        end else if (state_q == StRun && win_q != WinW'(WIN_CYC)) begin
            win_d = win_q + WinW'(1);
            if (win_d == WinW'(WIN_CYC)) retry_d = 2'd0;
        end
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        motor_en_d = 1'b0;
        dir_d      = dir_q;
        duty_d     = '0;
        fault_d    = 1'b0;
        case (state_d)
            StRun: begin
                motor_en_d = 1'b1;
                dir_d      = nav_dir;
                duty_d     = nav_duty;
            end
            StReverse: begin
                motor_en_d = 1'b1;
                dir_d      = DirRev;
                duty_d     = DUTY_W'(REV_DUTY);
            end
            StTurn: begin
                motor_en_d = 1'b1;
                dir_d      = side_d[1] ? DirSpinR : DirSpinL;
                duty_d     = DUTY_W'(REV_DUTY);
            end
            StFault: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            side_q     <= 2'b00;
            retry_q    <= 2'd0;
            win_q      <= '0;
            motor_en_q <= 1'b0;
            dir_q      <= DirFwd;
            duty_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            side_q     <= side_d;
            retry_q    <= retry_d;
            win_q      <= win_d;
            motor_en_q <= motor_en_d;
            dir_q      <= dir_d;
            duty_q     <= duty_d;
            fault_q    <= fault_d;
        end
    end

    assign motor_en  = motor_en_q;
    assign dir       = dir_q;
    assign duty      = duty_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign fault     = fault_q;

endmodule
